// File: rtl/tcam_lookup_ctrl_if.sv
// tcam_lookup_ctrl_if: lookup request/result, table-write and TCAM-side
// signals of tcam_lookup_ctrl, grouped with master (host/TCAM side) and
// slave (controller side) views.
interface tcam_lookup_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          LKUP_VALID;
  logic [DW-1:0] LKUP_KEY;
  logic [DW-1:0] LKUP_MASK;
  logic          LKUP_READY;

  logic          RES_VALID;
  logic          RES_HIT;
  logic [AW-1:0] RES_ADDR;

  logic          WR_REQ;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [DW-1:0] WR_MASK;
  logic          WR_ACK;

  logic          TCAM_WE;
  logic [AW-1:0] TCAM_WR_ADDR;
  logic [DW-1:0] TCAM_DIN;
  logic [DW-1:0] TCAM_DATA_MASK;
  logic          TCAM_BUSY;
  logic [DW-1:0] TCAM_CMP_DIN;
  logic [DW-1:0] TCAM_CMP_DATA_MASK;
  logic          TCAM_MATCH;
  logic [AW-1:0] TCAM_MATCH_ADDR;

  modport master (
    output LKUP_VALID, LKUP_KEY, LKUP_MASK,
    input  LKUP_READY,
    input  RES_VALID, RES_HIT, RES_ADDR,
    output WR_REQ, WR_ADDR, WR_DATA, WR_MASK,
    input  WR_ACK,
    input  TCAM_WE, TCAM_WR_ADDR, TCAM_DIN, TCAM_DATA_MASK,
    output TCAM_BUSY,
    input  TCAM_CMP_DIN, TCAM_CMP_DATA_MASK,
    output TCAM_MATCH, TCAM_MATCH_ADDR
  );

  modport slave (
    input  LKUP_VALID, LKUP_KEY, LKUP_MASK,
    output LKUP_READY,
    output RES_VALID, RES_HIT, RES_ADDR,
    input  WR_REQ, WR_ADDR, WR_DATA, WR_MASK,
    output WR_ACK,
    output TCAM_WE, TCAM_WR_ADDR, TCAM_DIN, TCAM_DATA_MASK,
    input  TCAM_BUSY,
    output TCAM_CMP_DIN, TCAM_CMP_DATA_MASK,
    input  TCAM_MATCH, TCAM_MATCH_ADDR
  );
endinterface

// File: rtl/tcam_lookup_ctrl.sv
// tcam_lookup_ctrl: pipelined TCAM lookup front-end with priority table
// writes. Lookups stream one per cycle; a write request stops new lookups,
// drains in-flight ones, issues a single TCAM_WE and waits for TCAM_BUSY.
// Optional hit/miss statistics are built when TCAM_LOOKUP_STATS_EN is defined.
module tcam_lookup_ctrl #(
  parameter int C_TCAM_ADDR_WIDTH = 5,
  parameter int C_TCAM_DATA_WIDTH = 32,
  parameter int C_LOOKUP_LATENCY  = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  tcam_lookup_ctrl_if.slave  bus,
  output logic [31:0]        HIT_CNT,
  output logic [31:0]        MISS_CNT
);

  typedef enum logic [1:0] {IDLE, DRAIN, WR_ISSUE, WR_WAIT} state_t;

  state_t                         r_state;
  logic                           r_we;
  logic                           r_ack;
  logic [C_TCAM_ADDR_WIDTH-1:0]   r_wr_addr;
  logic [C_TCAM_DATA_WIDTH-1:0]   r_wr_data;
  logic [C_TCAM_DATA_WIDTH-1:0]   r_wr_mask;

  logic [C_TCAM_DATA_WIDTH-1:0]   r_cmp_din;
  logic [C_TCAM_DATA_WIDTH-1:0]   r_cmp_mask;
  logic                           r_cmp_vld;
  logic [C_LOOKUP_LATENCY-1:0]    r_pipe;
  logic                           r_res_valid;
  logic                           r_res_hit;
  logic [C_TCAM_ADDR_WIDTH-1:0]   r_res_addr;

  logic                           w_ready;
  logic                           w_accept;
  logic                           w_pipe_empty;
  logic                           w_pipe_end;
  logic                           w_issue_ok;
  logic [C_LOOKUP_LATENCY-1:0]    w_pipe_next;

  // r_cmp_vld marks the cycle the key sits on TCAM_CMP_DIN; r_pipe then counts
  // the TCAM latency so its last stage lines up with a valid TCAM_MATCH.
  generate
    if (C_LOOKUP_LATENCY == 1) begin : g_pipe1
      assign w_pipe_next = r_cmp_vld;
    end else begin : g_pipen
      assign w_pipe_next = {r_pipe[C_LOOKUP_LATENCY-2:0], r_cmp_vld};
    end
  endgenerate

  assign w_ready      = (r_state == IDLE) & ~bus.TCAM_BUSY & ~bus.WR_REQ;
  assign w_accept     = bus.LKUP_VALID & w_ready;
  assign w_pipe_empty = ~r_cmp_vld & ~(|r_pipe);
  assign w_pipe_end   = r_pipe[C_LOOKUP_LATENCY-1];
  assign w_issue_ok   = w_pipe_empty & ~bus.TCAM_BUSY;

  // Write-control FSM; TCAM_WE and WR_ACK are registered single-cycle pulses.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_ack     <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_mask <= '0;
    end else begin
      r_we  <= 1'b0;
      r_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.WR_REQ) begin
            if (!w_pipe_empty) begin
              r_state <= DRAIN;
            end else if (!bus.TCAM_BUSY) begin
              r_state   <= WR_ISSUE;
              r_we      <= 1'b1;
              r_wr_addr <= bus.WR_ADDR;
              r_wr_data <= bus.WR_DATA;
              r_wr_mask <= bus.WR_MASK;
            end
          end
        end
        DRAIN: begin
          if (w_issue_ok) begin
            r_state   <= WR_ISSUE;
            r_we      <= 1'b1;
            r_wr_addr <= bus.WR_ADDR;
            r_wr_data <= bus.WR_DATA;
            r_wr_mask <= bus.WR_MASK;
          end
        end
        WR_ISSUE: r_state <= WR_WAIT;
        WR_WAIT: begin
          if (!bus.TCAM_BUSY) begin
            r_ack   <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Lookup datapath: capture key on accept, track it through the TCAM latency
  // and register the match result at the end of the pipeline.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cmp_din   <= '0;
      r_cmp_mask  <= '0;
      r_cmp_vld   <= 1'b0;
      r_pipe      <= '0;
      r_res_valid <= 1'b0;
      r_res_hit   <= 1'b0;
      r_res_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_cmp_din  <= bus.LKUP_KEY;
        r_cmp_mask <= bus.LKUP_MASK;
      end
      r_cmp_vld   <= w_accept;
      r_pipe      <= w_pipe_next;
      r_res_valid <= w_pipe_end;
      if (w_pipe_end) begin
        r_res_hit  <= bus.TCAM_MATCH;
        r_res_addr <= bus.TCAM_MATCH ? bus.TCAM_MATCH_ADDR : '0;
      end
    end
  end

`ifdef TCAM_LOOKUP_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating hit/miss counters, bumped on each result strobe.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_res_valid) begin
      if (r_res_hit && (r_hit_cnt != '1))
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (!r_res_hit && (r_miss_cnt != '1))
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign HIT_CNT  = r_hit_cnt;
  assign MISS_CNT = r_miss_cnt;
`else
  assign HIT_CNT  = '0;
  assign MISS_CNT = '0;
`endif

  assign bus.LKUP_READY         = w_ready;
  assign bus.RES_VALID          = r_res_valid;
  assign bus.RES_HIT            = r_res_hit;
  assign bus.RES_ADDR           = r_res_addr;
  assign bus.WR_ACK             = r_ack;
  assign bus.TCAM_WE            = r_we;
  assign bus.TCAM_WR_ADDR       = r_wr_addr;
  assign bus.TCAM_DIN           = r_wr_data;
  assign bus.TCAM_DATA_MASK     = r_wr_mask;
  assign bus.TCAM_CMP_DIN       = r_cmp_din;
  assign bus.TCAM_CMP_DATA_MASK = r_cmp_mask;

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb_tcam_lookup_ctrl: directed bench for tcam_lookup_ctrl with a small
// behavioural TCAM (latency 1, mask bit 1 = don't care, lowest address wins).
module tb_tcam_lookup_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef TCAM_LOOKUP_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_cnt, miss_cnt;
  always #5 clk = ~clk;

  tcam_lookup_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  tcam_lookup_ctrl #(
    .C_TCAM_ADDR_WIDTH(AW),
    .C_TCAM_DATA_WIDTH(DW),
    .C_LOOKUP_LATENCY (1)
  ) u_dut (
    .CLK     (clk),
    .RESET   (rst),
    .bus     (bus),
    .HIT_CNT (hit_cnt),
    .MISS_CNT(miss_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor
  logic    res_hit [64];
  logic [AW-1:0] res_addr [64];
  int      res_cyc [64];
  int      res_n = 0;
  always @(negedge clk) begin
    if (bus.RES_VALID === 1'b1 && res_n < 64) begin
      res_hit[res_n]  <= bus.RES_HIT;
      res_addr[res_n] <= bus.RES_ADDR;
      res_cyc[res_n]  <= cyc;
      res_n           <= res_n + 1;
    end
  end

  // Behavioural TCAM
  logic          t_v [32];
  logic [DW-1:0] t_d [32];
  logic [DW-1:0] t_m [32];
  int busy_len = 0;
  int busy_cnt = 0;
  assign bus.TCAM_BUSY = (busy_cnt != 0);

  always @(posedge clk) begin : tcam_model
    logic          h;
    logic [AW-1:0] a;
    h = 1'b0;
    a = '0;
    for (int i = 31; i >= 0; i--) begin
      if (t_v[i] === 1'b1 &&
          (((t_d[i] ^ bus.TCAM_CMP_DIN) & ~t_m[i] & ~bus.TCAM_CMP_DATA_MASK) == '0)) begin
        h = 1'b1;
        a = AW'(i);
      end
    end
    bus.TCAM_MATCH      <= h;
    bus.TCAM_MATCH_ADDR <= a;
    if (rst) begin
      for (int i = 0; i < 32; i++) t_v[i] <= 1'b0;
    end else if (bus.TCAM_WE) begin
      t_v[bus.TCAM_WR_ADDR] <= 1'b1;
      t_d[bus.TCAM_WR_ADDR] <= bus.TCAM_DIN;
      t_m[bus.TCAM_WR_ADDR] <= bus.TCAM_DATA_MASK;
    end
    if (bus.TCAM_WE === 1'b1 && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_lookup(input logic [DW-1:0] key, output int acc);
    bus.LKUP_VALID = 1'b1;
    bus.LKUP_KEY   = key;
    bus.LKUP_MASK  = '0;
    #1;
    chk("lkup_ready", 64'(bus.LKUP_READY), 64'd1);
    tick;
    acc = cyc;
    bus.LKUP_VALID = 1'b0;
    chk("cmp_din", 64'(bus.TCAM_CMP_DIN), 64'(key));
  endtask

  task automatic check_res(input int idx, input int acc, input logic h, input logic [AW-1:0] a);
    chk("res_latency", 64'(res_cyc[idx]), 64'(acc + 2));
    chk("res_hit", 64'(res_hit[idx]), 64'(h));
    chk("res_addr", 64'(res_addr[idx]), 64'(a));
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [DW-1:0] mask, output int we_cyc,
                          output int ack_cyc, output int we_cnt, output int rdy_bad);
    bus.WR_ADDR = addr;
    bus.WR_DATA = data;
    bus.WR_MASK = mask;
    bus.WR_REQ  = 1'b1;
    #1;
    we_cyc = -1; ack_cyc = -1; we_cnt = 0; rdy_bad = 0;
    for (int i = 0; i < 60 && ack_cyc < 0; i++) begin
      if (bus.LKUP_READY !== 1'b0) rdy_bad++;
      tick;
      if (bus.TCAM_WE === 1'b1) begin
        we_cnt++;
        we_cyc = cyc;
        bus.WR_DATA = ~data;          // must be ignored after capture
        bus.WR_ADDR = addr ^ 5'd1;
      end
      if (bus.WR_ACK === 1'b1) ack_cyc = cyc;
    end
    bus.WR_REQ = 1'b0;
    #1;
  endtask

  int acc, base, c0, we_c, ack_c, we_n, rb, fall_c, ack_seen, rv_seen;
  int accs [4];
  logic [DW-1:0] keys [4];
  logic          exp_h [4];
  logic [AW-1:0] exp_a [4];

  initial begin
    rst = 1'b1;
    bus.LKUP_VALID = 1'b0; bus.LKUP_KEY = '0; bus.LKUP_MASK = '0;
    bus.WR_REQ = 1'b0; bus.WR_ADDR = '0; bus.WR_DATA = '0; bus.WR_MASK = '0;
    repeat (3) tick;
    chk("rst_res_valid", 64'(bus.RES_VALID), 64'd0);
    chk("rst_tcam_we", 64'(bus.TCAM_WE), 64'd0);
    chk("rst_wr_ack", 64'(bus.WR_ACK), 64'd0);
    chk("rst_cmp_din", 64'(bus.TCAM_CMP_DIN), 64'd0);
    chk("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(bus.LKUP_READY), 64'd1);

    // Empty-table miss
    base = res_n;
    issue_lookup(32'hDEADBEEF, acc);
    repeat (4) tick;
    chk("miss_count", 64'(res_n - base), 64'd1);
    check_res(base, acc, 1'b0, '0);
    chk("miss_cnt_1", 64'(miss_cnt), 64'(STATS));

    // Write entry 3 from idle, then hit it
    c0 = cyc;
    do_write(5'd3, 32'h0000ABCD, 32'h0, we_c, ack_c, we_n, rb);
    chk("w3_we_cyc", 64'(we_c), 64'(c0 + 1));
    chk("w3_we_cnt", 64'(we_n), 64'd1);
    chk("w3_ack_cyc", 64'(ack_c), 64'(c0 + 3));
    chk("w3_wr_addr", 64'(bus.TCAM_WR_ADDR), 64'd3);
    chk("w3_din", 64'(bus.TCAM_DIN), 64'h0000ABCD);
    base = res_n;
    issue_lookup(32'h0000ABCD, acc);
    repeat (4) tick;
    chk("hit_count", 64'(res_n - base), 64'd1);
    check_res(base, acc, 1'b1, 5'd3);
    chk("hit_cnt_1", 64'(hit_cnt), 64'(STATS));

    // Write with a lookup in flight: drain first
    base = res_n;
    issue_lookup(32'hDEADBEEF, acc);
    do_write(5'd7, 32'h00001200, 32'h000000FF, we_c, ack_c, we_n, rb);
    chk("drain_res", 64'(res_n - base), 64'd1);
    check_res(base, acc, 1'b0, '0);
    chk("drain_we_cyc", 64'(we_c), 64'(acc + 3));
    chk("drain_we_cnt", 64'(we_n), 64'd1);
    chk("drain_ack_cyc", 64'(ack_c), 64'(acc + 5));
    chk("drain_ready_low", 64'(rb), 64'd0);
    chk("drain_dmask", 64'(bus.TCAM_DATA_MASK), 64'h000000FF);

    // Four back-to-back lookups
    keys[0] = 32'h0000ABCD; exp_h[0] = 1'b1; exp_a[0] = 5'd3;
    keys[1] = 32'hDEADBEEF; exp_h[1] = 1'b0; exp_a[1] = 5'd0;
    keys[2] = 32'h00001234; exp_h[2] = 1'b1; exp_a[2] = 5'd7;
    keys[3] = 32'h000012FF; exp_h[3] = 1'b1; exp_a[3] = 5'd7;
    base = res_n;
    for (int i = 0; i < 4; i++) issue_lookup(keys[i], accs[i]);
    repeat (5) tick;
    chk("b2b_count", 64'(res_n - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_accept_cyc", 64'(accs[i]), 64'(accs[0] + i));
      check_res(base + i, accs[i], exp_h[i], exp_a[i]);
    end
    chk("b2b_hit_cnt", 64'(hit_cnt), 64'(STATS * 4));
    chk("b2b_miss_cnt", 64'(miss_cnt), 64'(STATS * 3));

    // TCAM busy for 5 cycles after the write strobe
    busy_len = 5;
    c0 = cyc;
    bus.WR_ADDR = 5'd9; bus.WR_DATA = 32'h55; bus.WR_MASK = '0; bus.WR_REQ = 1'b1;
    #1;
    we_c = -1; ack_c = -1; fall_c = -1; we_n = 0;
    for (int i = 0; i < 40 && ack_c < 0; i++) begin
      tick;
      if (bus.TCAM_WE === 1'b1) begin
        we_n++; we_c = cyc;
        bus.WR_DATA = 32'hFFFF0000;
      end
      if (we_c >= 0 && cyc > we_c + 1 && fall_c < 0 && bus.TCAM_BUSY === 1'b0) fall_c = cyc;
      if (bus.WR_ACK === 1'b1) ack_c = cyc;
    end
    bus.WR_REQ = 1'b0;
    #1;
    chk("busy_we_cyc", 64'(we_c), 64'(c0 + 1));
    chk("busy_we_cnt", 64'(we_n), 64'd1);
    chk("busy_fall_cyc", 64'(fall_c), 64'(c0 + 7));
    chk("busy_ack_cyc", 64'(ack_c), 64'(c0 + 8));
    chk("busy_din_held", 64'(bus.TCAM_DIN), 64'h55);

    // Reset while waiting on a busy TCAM
    busy_len = 20;
    bus.WR_ADDR = 5'd5; bus.WR_DATA = 32'h77; bus.WR_REQ = 1'b1;
    for (int i = 0; i < 20 && bus.TCAM_WE !== 1'b1; i++) tick;
    tick;
    tick;
    rst = 1'b1;
    #1;
    chk("rr_res_valid", 64'(bus.RES_VALID), 64'd0);
    chk("rr_res_hit", 64'(bus.RES_HIT), 64'd0);
    chk("rr_res_addr", 64'(bus.RES_ADDR), 64'd0);
    chk("rr_wr_ack", 64'(bus.WR_ACK), 64'd0);
    chk("rr_tcam_we", 64'(bus.TCAM_WE), 64'd0);
    chk("rr_wr_addr", 64'(bus.TCAM_WR_ADDR), 64'd0);
    chk("rr_din", 64'(bus.TCAM_DIN), 64'd0);
    chk("rr_dmask", 64'(bus.TCAM_DATA_MASK), 64'd0);
    chk("rr_cmp_din", 64'(bus.TCAM_CMP_DIN), 64'd0);
    chk("rr_cmp_mask", 64'(bus.TCAM_CMP_DATA_MASK), 64'd0);
    chk("rr_hit_cnt", 64'(hit_cnt), 64'd0);
    chk("rr_miss_cnt", 64'(miss_cnt), 64'd0);
    tick;
    rst = 1'b0;
    bus.WR_REQ = 1'b0;
    #1;
    chk("rr_ready_busy", 64'(bus.LKUP_READY), 64'd0);
    ack_seen = 0; rv_seen = 0;
    for (int i = 0; i < 40 && bus.TCAM_BUSY === 1'b1; i++) begin
      tick;
      if (bus.WR_ACK === 1'b1) ack_seen++;
      if (bus.RES_VALID === 1'b1) rv_seen++;
    end
    repeat (3) begin
      tick;
      if (bus.WR_ACK === 1'b1) ack_seen++;
      if (bus.RES_VALID === 1'b1) rv_seen++;
    end
    chk("rr_busy_released", 64'(bus.TCAM_BUSY), 64'd0);
    chk("rr_ready_after", 64'(bus.LKUP_READY), 64'd1);
    chk("rr_no_ack", 64'(ack_seen), 64'd0);
    chk("rr_no_res", 64'(rv_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
